// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register
// names, fetch FSM states and the instruction-length table.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PRESENT = 2'd2,
        S_HALTED  = 2'd3
    } fetch_state_t;

    // Instruction length in bytes; unknown icodes count as one byte so the
    // range check and valP stay well defined for INS instructions.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
            I_JXX, I_CALL:                    instr_len = 4'd9;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_split.sv
// Combinational instruction splitter: decodes the ten bytes at pc into
// fields, next sequential PC, length and fetch status.
module fetch_split
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic [79:0] ibytes,   // byte i of the instruction at [8*i +: 8]
    input  logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [3:0]  length,
    output logic [2:0]  stat
);

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    logic [64:0] end_addr;
    logic        ifun_ok;

    // Field extraction, length, valP and the prioritised status decision.
    always_comb begin
        icode    = ibytes[7:4];
        ifun     = ibytes[3:0];
        length   = instr_len(icode);
        rA       = REG_NONE;
        rB       = REG_NONE;
        valC     = '0;
        ifun_ok  = (ifun == 4'd0);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                rA = ibytes[15:12];
                rB = ibytes[11:8];
            end
            default: ;
        endcase
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valC = ibytes[79:16];
            I_JXX, I_CALL:                valC = ibytes[71:8];
            default: ;
        endcase
        case (icode)
            I_OPQ:           ifun_ok = (ifun <= 4'd3);
            I_JXX, I_RRMOVQ: ifun_ok = (ifun <= 4'd6);
            default: ;
        endcase
        valP = pc + 64'(length);
        // 65-bit arithmetic so a PC near the top of the address space
        // cannot wrap back into range.
        end_addr = {1'b0, pc} + 65'(length) - 65'd1;
        if (({1'b0, pc} >= MEM_LIMIT) || (end_addr >= MEM_LIMIT)) begin
            stat = STAT_ADR;
        end else if ((icode > I_POPQ) || !ifun_ok) begin
            stat = STAT_INS;
        end else if (icode == I_HALT) begin
            stat = STAT_HLT;
        end else begin
            stat = STAT_AOK;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch stage: PC register, byte-addressed instruction memory,
// and a registered output bundle handed to decode/execute.
// Handshake: the bundle is valid in PRESENT/HALTED; step in PRESENT means
// the bundle was consumed and new_pc is the next PC to fetch.
module fetch_unit
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_wdata,
    input  logic              start,
    input  logic [63:0]       pc_start,
    input  logic              step,
    input  logic [63:0]       new_pc,
    output logic [63:0]       pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [63:0]       valP,
    output logic [2:0]        stat,
    output logic              valid
);

    logic [7:0]   mem [MEM_BYTES];
    logic [79:0]  ibytes;
    logic [64:0]  rd_addr;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         take_start;
    logic         take_step;
    logic         do_load;

    logic [3:0]   s_icode;
    logic [3:0]   s_ifun;
    logic [3:0]   s_ra;
    logic [3:0]   s_rb;
    logic [63:0]  s_valc;
    logic [63:0]  s_valp;
    logic [3:0]   s_len;
    logic [2:0]   s_stat;

    // Memory load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we && (32'(imem_addr) < 32'(MEM_BYTES))) begin
            mem[imem_addr] <= imem_wdata;
        end
    end

    // Asynchronous ten-byte read at pc; out-of-range bytes read as zero.
    // A same-cycle write lands after this read, giving read-before-write.
    always_comb begin
        ibytes  = '0;
        rd_addr = '0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = {1'b0, pc} + 65'(i);
            if (rd_addr < 65'(MEM_BYTES)) begin
                ibytes[8*i +: 8] = mem[rd_addr[ADDR_W-1:0]];
            end
        end
    end

    fetch_split #(
        .MEM_BYTES (MEM_BYTES)
    ) u_split (
        .ibytes (ibytes),
        .pc     (pc),
        .icode  (s_icode),
        .ifun   (s_ifun),
        .rA     (s_ra),
        .rB     (s_rb),
        .valC   (s_valc),
        .valP   (s_valp),
        .length (s_len),
        .stat   (s_stat)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD;
            S_LOAD:    state_d = (s_stat == STAT_AOK) ? S_PRESENT : S_HALTED;
            S_PRESENT: if (step) state_d = S_LOAD;
            S_HALTED:  if (start) state_d = S_LOAD;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM control strobes; step has priority because start is only
    // honoured where step is not.
    always_comb begin
        take_start = start && ((state_q == S_IDLE) || (state_q == S_HALTED));
        take_step  = step && (state_q == S_PRESENT);
        do_load    = (state_q == S_LOAD);
    end

    // PC and output bundle registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            icode <= I_HALT;
            ifun  <= 4'd0;
            rA    <= REG_NONE;
            rB    <= REG_NONE;
            valC  <= '0;
            valP  <= '0;
            stat  <= STAT_AOK;
            valid <= 1'b0;
        end else if (take_start) begin
            pc    <= pc_start;
            valid <= 1'b0;
        end else if (take_step) begin
            pc    <= new_pc;
            valid <= 1'b0;
        end else if (do_load) begin
            icode <= s_icode;
            ifun  <= s_ifun;
            rA    <= s_ra;
            rB    <= s_rb;
            valC  <= s_valc;
            valP  <= s_valp;
            stat  <= s_stat;
            valid <= 1'b1;
        end
    end

endmodule
